// File: rtl/eeprom_boot_loader_pkg.sv
// Shared types and constants for the EEPROM boot loader.
// The optional checksum is enabled with EEPROM_BOOT_CSUM_EN.
package eeprom_boot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam int WORD_STRIDE = 4;
    localparam int WORD_CNT_DEF = 16;

    function automatic int cnt_width(input int n);
        return (n + 1 > 1) ? $clog2(n + 1) : 1;
    endfunction

    localparam int CNT_W = cnt_width(WORD_CNT_DEF);

endpackage

// File: rtl/eeprom_boot_loader_if.sv
// APB bus between the boot loader (master) and the EEPROM slave.
// Bus-level plumbing only; no logic lives here.
interface eeprom_boot_loader_if #(
    parameter int AWIDTH = 10
);

    logic [AWIDTH-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr,
        output pwrite,
        output psel,
        output penable,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  paddr,
        input  pwrite,
        input  psel,
        input  penable,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );

endinterface

// File: rtl/eeprom_boot_loader_csum.sv
// Running 32-bit checksum over the copied words, compared to the last word.
// Built only when EEPROM_BOOT_CSUM_EN is defined.
module eeprom_boot_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add,
    input  logic        check,
    input  logic [31:0] data,
    output logic        csum_err
);

    logic [31:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            csum_err <= 1'b0;
        end else if (clear) begin
            sum      <= '0;
            csum_err <= 1'b0;
        end else begin
            if (add) begin
                sum <= sum + data;
            end
            if (check && (sum != data)) begin
                csum_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/eeprom_boot_loader.sv
// APB master copying WORD_CNT words from the EEPROM into on-chip memory.
// Optional checksum: define EEPROM_BOOT_CSUM_EN.
module eeprom_boot_loader
    import eeprom_boot_pkg::*;
#(
    parameter int AWIDTH   = 10,
    parameter int MWIDTH   = 8,
    parameter int WORD_CNT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AWIDTH-1:0]    eep_base,
    input  logic [MWIDTH-1:0]    mem_base,
    eeprom_boot_loader_if.master apb,
    output logic                 mem_we,
    output logic [MWIDTH-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AWIDTH-1:0]    err_addr,
    output logic                 csum_err
);

    localparam int KW = cnt_width(WORD_CNT);
    localparam logic [KW-1:0] K_LAST = KW'(WORD_CNT);
    localparam logic [AWIDTH-1:0] STRIDE = AWIDTH'(WORD_STRIDE);

    state_t state;
    state_t state_nx;

    logic [KW-1:0]     k;
    logic [KW-1:0]     k_nx;
    logic [KW-1:0]     k_rsp;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] prev_q;
    logic [AWIDTH-1:0] base_q;
    logic [AWIDTH-1:0] base_in;
    logic [MWIDTH-1:0] mbase_q;

    logic accept;
    logic complete;
    logic has_rsp;
    logic last;
    logic nak;

    always_comb begin
        accept   = (state == IDLE) && start;
        complete = (state == ACCESS) && apb.pready;
        has_rsp  = (k != '0);
        last     = (k == K_LAST);
        nak      = complete && has_rsp && apb.pslverr;
        k_nx     = k + KW'(1);
        k_rsp    = k - KW'(1);
        base_in  = eep_base & ~AWIDTH'(3);
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (complete) begin
                    state_nx = (nak || last) ? DONE : SETUP;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Responses lag one transfer: completion k carries word k-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            addr_q    <= '0;
            prev_q    <= '0;
            base_q    <= '0;
            mbase_q   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                k       <= '0;
                base_q  <= base_in;
                addr_q  <= base_in;
                prev_q  <= base_in;
                mbase_q <= mem_base;
                err     <= 1'b0;
            end
            if (complete) begin
                if (nak) begin
                    err      <= 1'b1;
                    err_addr <= prev_q;
                end else begin
                    if (has_rsp) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= mbase_q + MWIDTH'(k_rsp);
                        mem_wdata <= apb.prdata;
                    end
                    if (!last) begin
                        k      <= k_nx;
                        prev_q <= addr_q;
                        // Final transfer only flushes the last response.
                        addr_q <= (k_nx == K_LAST) ? base_q : addr_q + STRIDE;
                    end
                end
            end
        end
    end

    assign apb.psel    = (state == SETUP) || (state == ACCESS);
    assign apb.penable = (state == ACCESS);
    assign apb.paddr   = addr_q;
    assign apb.pwrite  = 1'b0;
    assign apb.pwdata  = '0;
    assign busy        = (state == SETUP) || (state == ACCESS);
    assign done        = (state == DONE);

`ifdef EEPROM_BOOT_CSUM_EN
    logic csum_add;
    logic csum_chk;

    assign csum_add = complete && !nak && has_rsp && !last;
    assign csum_chk = complete && !nak && last;

    eeprom_boot_csum u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .add      (csum_add),
        .check    (csum_chk),
        .data     (apb.prdata),
        .csum_err (csum_err)
    );
`else
    assign csum_err = 1'b0;
`endif

endmodule
